// File: rtl/regfile_scoreboard.sv
// Integer register file with a pending-write scoreboard for hazard stalls.
// Optional same-cycle write-back bypass: define REGFILE_WB_BYPASS_EN.
module regfile_scoreboard #(
    parameter int XLEN         = 32,
    parameter int MSB_REG_FILE = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MSB_REG_FILE-1:0] rs1,
    input  logic [MSB_REG_FILE-1:0] rs2,
    output logic [XLEN-1:0]         rs1Data,
    output logic [XLEN-1:0]         rs2Data,
    input  logic [XLEN-1:0]         rdData,
    input  logic [MSB_REG_FILE-1:0] rdIn,
    input  logic                    writeEn,
    input  logic                    issue_valid,
    input  logic [MSB_REG_FILE-1:0] issue_rd,
    input  logic                    flush,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic [MSB_REG_FILE:0]   pending_cnt
);

    localparam int DEPTH = 1 << MSB_REG_FILE;
    localparam int CNT_W = MSB_REG_FILE + 1;

    logic [DEPTH-1:0][XLEN-1:0] mem_q;
    logic [DEPTH-1:0]           busy_q, busy_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic wr_ok, iss_ok;
    logic hit1, hit2;

    assign wr_ok  = writeEn && (rdIn != '0);
    assign iss_ok = issue_valid && (issue_rd != '0) && !flush;

    // Array storage; x0 is never written so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (wr_ok) begin
            mem_q[rdIn] <= rdData;
        end
    end

    // Per-register busy next state: flush > issue set > write-back clear.
    assign busy_d[0] = 1'b0;
    for (genvar i = 1; i < DEPTH; i++) begin : g_busy
        logic set_i, clr_i;
        assign set_i = iss_ok && (issue_rd == MSB_REG_FILE'(i));
        assign clr_i = wr_ok && (rdIn == MSB_REG_FILE'(i));
        always_comb begin
            busy_d[i] = busy_q[i];
            if (flush)      busy_d[i] = 1'b0;
            else if (set_i) busy_d[i] = 1'b1;
            else if (clr_i) busy_d[i] = 1'b0;
        end
    end

    // Count from busy_d so pending_cnt tracks busy_q exactly after each edge.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    assign hit1 = writeEn && (rdIn == rs1) && (rs1 != '0);
    assign hit2 = writeEn && (rdIn == rs2) && (rs2 != '0);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    always_comb begin
        rs1Data = (rs1 == '0) ? '0 : mem_q[rs1];
        rs2Data = (rs2 == '0) ? '0 : mem_q[rs2];
        if (hit1) rs1Data = rdData;
        if (hit2) rs2Data = rdData;
    end

    assign rs1_busy    = busy_q[rs1] && !hit1;
    assign rs2_busy    = busy_q[rs2] && !hit2;
    assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (both bypass builds).
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, rdIn, issue_rd;
    logic [31:0] rs1Data, rs2Data, rdData;
    logic        writeEn, issue_valid, flush;
    logic        rs1_busy, rs2_busy;
    logic [5:0]  pending_cnt;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(.XLEN(32), .MSB_REG_FILE(5)) dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .rs1Data(rs1Data), .rs2Data(rs2Data),
        .rdData(rdData), .rdIn(rdIn), .writeEn(writeEn),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        writeEn = 0; issue_valid = 0; flush = 0; rst = 0;
    endtask

    initial begin
        rst = 1; rs1 = 0; rs2 = 0; rdIn = 0; issue_rd = 0; rdData = 0;
        writeEn = 0; issue_valid = 0; flush = 0;
        tick(); tick();
        idle();
        rs1 = 1; rs2 = 31; #1;
        check("rst_rs1Data", rs1Data, 0);
        check("rst_rs2Data", rs2Data, 0);
        check("rst_rs1_busy", 32'(rs1_busy), 0);
        check("rst_rs2_busy", 32'(rs2_busy), 0);
        check("rst_cnt", 32'(pending_cnt), 0);

        // write x5, read next cycle
        writeEn = 1; rdIn = 5; rdData = 32'hDEADBEEF;
        tick(); idle();
        rs1 = 5; #1;
        check("wr_x5", rs1Data, 32'hDEADBEEF);

        // write x0 dropped
        writeEn = 1; rdIn = 0; rdData = 32'h1234;
        tick(); idle();
        rs2 = 0; #1;
        check("wr_x0", rs2Data, 0);

        // issue x7 sets busy
        issue_valid = 1; issue_rd = 7;
        tick(); idle();
        rs1 = 7; #1;
        check("iss7_busy", 32'(rs1_busy), 1);
        check("iss7_cnt", 32'(pending_cnt), 1);

        // issue x0 never marks
        issue_valid = 1; issue_rd = 0;
        tick(); idle();
        rs2 = 0; #1;
        check("iss0_busy", 32'(rs2_busy), 0);
        check("iss0_cnt", 32'(pending_cnt), 1);

        // write-back x7 clears busy
        writeEn = 1; rdIn = 7; rdData = 32'h55;
        tick(); idle();
        #1;
        check("wb7_busy", 32'(rs1_busy), 0);
        check("wb7_data", rs1Data, 32'h55);
        check("wb7_cnt", 32'(pending_cnt), 0);

        // same-cycle write-back and read of x3 (busy, old value 0x77)
        writeEn = 1; rdIn = 3; rdData = 32'h77;
        tick(); idle();
        issue_valid = 1; issue_rd = 3;
        tick(); idle();
        writeEn = 1; rdIn = 3; rdData = 32'hA; rs1 = 3; rs2 = 3; #1;
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_rs1Data", rs1Data, 32'hA);
        check("byp_rs1_busy", 32'(rs1_busy), 0);
        check("byp_rs2Data", rs2Data, 32'hA);
`else
        check("nobyp_rs1Data", rs1Data, 32'h77);
        check("nobyp_rs1_busy", 32'(rs1_busy), 1);
        check("nobyp_rs2Data", rs2Data, 32'h77);
`endif
        tick(); idle();
        #1;
        check("x3_after_data", rs1Data, 32'hA);
        check("x3_after_busy", 32'(rs1_busy), 0);
        check("x3_after_cnt", 32'(pending_cnt), 0);

        // same-cycle issue and write-back of x9: set wins
        issue_valid = 1; issue_rd = 9;
        tick(); idle();
        issue_valid = 1; issue_rd = 9; writeEn = 1; rdIn = 9; rdData = 32'h99;
        tick(); idle();
        rs1 = 9; #1;
        check("x9_busy", 32'(rs1_busy), 1);
        check("x9_data", rs1Data, 32'h99);
        check("x9_cnt", 32'(pending_cnt), 1);
        writeEn = 1; rdIn = 9; rdData = 32'h99;
        tick(); idle();
        check("x9_clr_cnt", 32'(pending_cnt), 0);

        // three issues then flush with concurrent issue x4 and write x12
        for (int r = 1; r <= 3; r++) begin
            issue_valid = 1; issue_rd = 5'(r);
            tick(); idle();
        end
        check("pre_flush_cnt", 32'(pending_cnt), 3);
        flush = 1; issue_valid = 1; issue_rd = 4;
        writeEn = 1; rdIn = 12; rdData = 32'hC0FFEE;
        tick(); idle();
        rs1 = 4; rs2 = 1; #1;
        check("flush_cnt", 32'(pending_cnt), 0);
        check("flush_x4_busy", 32'(rs1_busy), 0);
        check("flush_x1_busy", 32'(rs2_busy), 0);
        rs2 = 12; #1;
        check("flush_wr_x12", rs2Data, 32'hC0FFEE);

        // reset wins over same-cycle issue and write
        issue_valid = 1; issue_rd = 5; writeEn = 1; rdIn = 6; rdData = 32'h66; rst = 1;
        tick(); idle();
        rs1 = 5; rs2 = 6; #1;
        check("rstprio_x5_data", rs1Data, 0);
        check("rstprio_x5_busy", 32'(rs1_busy), 0);
        check("rstprio_x6_data", rs2Data, 0);
        check("rstprio_cnt", 32'(pending_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
